// File: rtl/dyn_pkg.sv
// dyn_pkg: shared word format, saturation limits and FSM state type for the joint dynamics integrator
package dyn_pkg;
  localparam int DATA_W = 32;
  localparam int FRAC_W = 16;
  localparam logic [DATA_W-1:0] Q_ONE = DATA_W'(1) << FRAC_W;
  localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};
  typedef logic signed [DATA_W-1:0] q_t;
  typedef enum logic [2:0] {IDLE, DAMP, ACCL, VEL, POS, DONE} state_t;
endpackage

// File: rtl/dyn_qmul_sat.sv
// dyn_qmul_sat: combinational Q-format multiply (a*b >>> FRAC_W, floor) saturated to DATA_W, sat flags clipping
module dyn_qmul_sat #(
  parameter int DATA_W = dyn_pkg::DATA_W,
  parameter int FRAC_W = dyn_pkg::FRAC_W
) (
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [DATA_W-1:0] y,
  output logic                     sat
);
  logic signed [2*DATA_W-1:0] prod;
  logic signed [2*DATA_W-1:0] shr;
  always_comb begin
    prod = a * b;
    shr  = prod >>> FRAC_W;
    sat  = shr[2*DATA_W-1:DATA_W-1] != {(DATA_W+1){shr[2*DATA_W-1]}};
    y    = sat ? {shr[2*DATA_W-1], {(DATA_W-1){~shr[2*DATA_W-1]}}} : shr[DATA_W-1:0];
  end
endmodule

// File: rtl/dyn_euler_step.sv
// dyn_euler_step: semi-implicit Euler joint integrator (DAMP->ACCL->VEL->POS->DONE) on one shared saturating multiplier
module dyn_euler_step import dyn_pkg::*; #(
  parameter int DATA_W = dyn_pkg::DATA_W,
  parameter int FRAC_W = dyn_pkg::FRAC_W
) (
  input  logic                     ACLK,
  input  logic                     ARESETN,
  input  logic                     step_valid,
  output logic                     step_ready,
  input  logic                     init_load,
  input  logic signed [DATA_W-1:0] init_pos,
  input  logic signed [DATA_W-1:0] init_vel,
  input  logic signed [DATA_W-1:0] tau,
  input  logic signed [DATA_W-1:0] damp_b,
  input  logic signed [DATA_W-1:0] inv_inertia,
  input  logic signed [DATA_W-1:0] dt,
  input  logic                     clr_sat,
  output logic signed [DATA_W-1:0] pos,
  output logic signed [DATA_W-1:0] vel,
  output logic signed [DATA_W-1:0] acc,
  output logic                     out_valid,
  output logic                     busy,
  output logic                     sat_sticky
);
  state_t state;
  logic signed [DATA_W-1:0] tau_r, b_r, inv_r, dt_r, d_r, pos_r, vel_r, acc_r;
  logic signed [DATA_W-1:0] ma, mb, my, aa, ay;
  logic signed [DATA_W:0]   sum;
  logic                     msat, asat;
  dyn_qmul_sat #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) u_mul (.a(ma), .b(mb), .y(my), .sat(msat));
  always_comb begin
    ma   = state == DAMP ? b_r : state == ACCL ? d_r : state == VEL ? acc_r : state == POS ? vel_r : '0;
    mb   = state == DAMP ? vel_r : state == ACCL ? inv_r : (state == VEL || state == POS) ? dt_r : '0;
    aa   = state == DAMP ? tau_r : state == VEL ? vel_r : state == POS ? pos_r : '0;
    sum  = state == DAMP ? {aa[DATA_W-1], aa} - {my[DATA_W-1], my} : {aa[DATA_W-1], aa} + {my[DATA_W-1], my};
    asat = sum[DATA_W] != sum[DATA_W-1];
    ay   = asat ? {sum[DATA_W], {(DATA_W-1){~sum[DATA_W]}}} : sum[DATA_W-1:0];
  end
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state      <= IDLE;
      tau_r      <= '0;
      b_r        <= '0;
      inv_r      <= '0;
      dt_r       <= '0;
      d_r        <= '0;
      pos_r      <= '0;
      vel_r      <= '0;
      acc_r      <= '0;
      sat_sticky <= 1'b0;
    end else begin
      sat_sticky <= msat | asat | (sat_sticky & ~clr_sat);
      case (state)
        IDLE: begin
          if (init_load) begin
            pos_r <= init_pos;
            vel_r <= init_vel;
          end else if (step_valid) begin
            tau_r <= tau;
            b_r   <= damp_b;
            inv_r <= inv_inertia;
            dt_r  <= dt;
            state <= DAMP;
          end
        end
        DAMP: begin
          d_r   <= ay;
          state <= ACCL;
        end
        ACCL: begin
          acc_r <= my;
          state <= VEL;
        end
        VEL: begin
          vel_r <= ay;
          state <= POS;
        end
        POS: begin
          pos_r <= ay;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign step_ready = (state == IDLE) && ARESETN;
  assign busy       = state != IDLE;
  assign out_valid  = state == DONE;
  assign pos        = pos_r;
  assign vel        = vel_r;
  assign acc        = acc_r;
endmodule
